// File: rtl/uart_tx.sv
// UART transmitter: byte FIFO behind a valid/ready handshake, serialised as
// start + 8 data bits (LSB first) + optional parity + stop on a registered tx.
module uart_tx #(
    parameter int CLOCK_HZ   = 10,
    parameter int BAUD_RATE  = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY     = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          valid,
    input  logic [7:0]                    data,
    output logic                          ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int CPB = CLOCK_HZ / BAUD_RATE;
    localparam int CW  = $clog2(CPB);
    localparam int AW  = $clog2(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [2:0]    state;
    logic [CW-1:0] baud_cnt;
    logic [7:0]    shift;
    logic [2:0]    bit_idx;
    logic          par_bit;
    logic          push, load, bit_end;

    assign ready   = !reset && (count != (AW+1)'(FIFO_DEPTH));
    assign push    = valid && ready;
    assign bit_end = (baud_cnt == CW'(CPB - 1));
    // A new frame starts either from idle or straight out of a finishing stop bit.
    assign load    = (count != '0) && ((state == S_IDLE) || (state == S_STOP && bit_end));
    assign busy    = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (load) rd_ptr <= rd_ptr + 1'b1;
            if (push && !load)      count <= count + 1'b1;
            else if (!push && load) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            tx       <= 1'b1;
            baud_cnt <= '0;
            shift    <= '0;
            bit_idx  <= '0;
            par_bit  <= 1'b0;
        end else if (load) begin
            shift    <= mem[rd_ptr];
            par_bit  <= (^mem[rd_ptr]) ^ (PARITY == 2);
            baud_cnt <= '0;
            tx       <= 1'b0;
            state    <= S_START;
        end else if (state != S_IDLE) begin
            baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
            if (bit_end) begin
                unique case (state)
                    S_START: begin
                        tx      <= shift[0];
                        bit_idx <= '0;
                        state   <= S_DATA;
                    end
                    S_DATA: begin
                        if (bit_idx != 3'd7) begin
                            shift   <= shift >> 1;
                            bit_idx <= bit_idx + 1'b1;
                            tx      <= shift[1];
                        end else if (PARITY != 0) begin
                            tx    <= par_bit;
                            state <= S_PARITY;
                        end else begin
                            tx    <= 1'b1;
                            state <= S_STOP;
                        end
                    end
                    S_PARITY: begin
                        tx    <= 1'b1;
                        state <= S_STOP;
                    end
                    S_STOP: begin
                        // FIFO empty here, otherwise load would have won.
                        tx    <= 1'b1;
                        state <= S_IDLE;
                    end
                    default: begin
                        tx    <= 1'b1;
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four instances cover CPB=4 with no/even/odd
// parity and CPB=2; frames are sampled on the falling clock edge.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       reset [4];
    logic       valid [4];
    logic [7:0] data  [4];
    logic       ready [4];
    logic       tx    [4];
    logic       busy  [4];
    logic [2:0] count [4];
    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        uart_tx #(
            .CLOCK_HZ  (g == 3 ? 20 : 40),
            .BAUD_RATE (10),
            .FIFO_DEPTH(4),
            .PARITY    (g == 1 ? 1 : (g == 2 ? 2 : 0))
        ) u_dut (
            .clk  (clk),
            .reset(reset[g]),
            .valid(valid[g]),
            .data (data[g]),
            .ready(ready[g]),
            .tx   (tx[g]),
            .busy (busy[g]),
            .count(count[g])
        );
    end

    // Samples nb bits of cpb cycles each; glitches counts tx changes inside a bit or busy low.
    task automatic capture_frame(input int k, input int cpb, input int nb,
                                 output logic [10:0] got, output int glitches);
        got = '0;
        glitches = 0;
        for (int i = 0; i < nb; i++) begin
            for (int j = 0; j < cpb; j++) begin
                if (j == 0) got[i] = tx[k];
                else if (tx[k] !== got[i]) glitches++;
                if (busy[k] !== 1'b1) glitches++;
                @(negedge clk);
            end
        end
    endtask

    task automatic wait_start(input int k, output int t, output bit ok);
        ok = 1'b0;
        t  = -1;
        for (int i = 0; i < 100; i++) begin
            if (tx[k] === 1'b0) begin
                ok = 1'b1;
                t  = cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 4; k++) begin
            reset[k] = 1'b1;
            valid[k] = 1'b0;
            data[k]  = 8'h00;
        end
        @(negedge clk);
        checks++;
        if ({tx[0], busy[0], count[0]} !== 5'b1_0_000) begin
            errors++;
            $display("FAIL reset_state tx/busy/count=%b expected 10000", {tx[0], busy[0], count[0]});
        end
        checks++;
        if (ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready got=%b expected 0", ready[0]);
        end
        for (int k = 0; k < 4; k++) reset[k] = 1'b0;
        @(negedge clk);
        checks++;
        if (ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset got=%b expected 1", ready[0]);
        end
    endtask

    task automatic test_basic_frame();
        logic [10:0] got;
        int gl;
        @(negedge clk);
        valid[0] = 1'b1;
        data[0]  = 8'hA5;
        @(negedge clk);
        valid[0] = 1'b0;
        checks++;
        if ({count[0], tx[0], busy[0]} !== 5'b001_1_0) begin
            errors++;
            $display("FAIL accept count/tx/busy=%b expected 001_1_0", {count[0], tx[0], busy[0]});
        end
        @(negedge clk);
        checks++;
        if ({count[0], tx[0], busy[0]} !== 5'b000_0_1) begin
            errors++;
            $display("FAIL pop_edge count/tx/busy=%b expected 000_0_1", {count[0], tx[0], busy[0]});
        end
        capture_frame(0, 4, 10, got, gl);
        checks++;
        if (got !== {2'b01, 8'hA5, 1'b0} || gl != 0) begin
            errors++;
            $display("FAIL frame_a5 got=%b glitches=%0d expected %b", got, gl, {2'b01, 8'hA5, 1'b0});
        end
        checks++;
        if (tx[0] !== 1'b1 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL a5_end tx=%b busy=%b expected 1 0", tx[0], busy[0]);
        end
    endtask

    task automatic test_parity();
        logic [10:0] got;
        logic [10:0] exp_f [3];
        int gl, t;
        bit ok;
        exp_f[1] = {1'b1, 1'b1, 8'h07, 1'b0};
        exp_f[2] = {1'b1, 1'b0, 8'h07, 1'b0};
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            valid[k] = 1'b1;
            data[k]  = 8'h07;
            @(negedge clk);
            valid[k] = 1'b0;
            wait_start(k, t, ok);
            capture_frame(k, 4, 11, got, gl);
            checks++;
            if (!ok || got !== exp_f[k] || gl != 0 || busy[k] !== 1'b0 || tx[k] !== 1'b1) begin
                errors++;
                $display("FAIL parity_mode%0d got=%b glitches=%0d busy_end=%b expected %b",
                         k, got, gl, busy[k], exp_f[k]);
            end
        end
    endtask

    task automatic test_fifo_stream();
        logic [7:0]  seq [6];
        int          acc [6];
        int          fs  [6];
        logic [10:0] got [6];
        int          gl  [6];
        int          t_end, idx, guard, t0;
        bit          full_ok, r, ok;
        seq = '{8'h00, 8'hFF, 8'h55, 8'h3C, 8'h81, 8'h12};
        for (int i = 0; i < 6; i++) begin
            acc[i] = -100;
            fs[i]  = -200;
        end
        full_ok = 1'b0;
        t_end   = 0;
        @(negedge clk);
        fork
            begin
                idx   = 0;
                guard = 0;
                while (idx < 6 && guard < 400) begin
                    data[0]  = seq[idx];
                    valid[0] = 1'b1;
                    r        = ready[0];
                    @(negedge clk);
                    guard++;
                    if (r) begin
                        acc[idx] = cyc;
                        if (idx == 4) full_ok = (count[0] === 3'd4) && (ready[0] === 1'b0);
                        idx++;
                    end
                end
                valid[0] = 1'b0;
            end
            begin
                wait_start(0, t0, ok);
                fs[0] = t0;
                for (int f = 0; f < 6; f++) begin
                    fs[f] = cyc;
                    capture_frame(0, 4, 10, got[f], gl[f]);
                end
                t_end = cyc;
                if (!ok) t_end = -1;
            end
        join
        checks++;
        if (fs[0] != acc[0] + 1) begin
            errors++;
            $display("FAIL stream_pop_latency accept=%0d start=%0d expected start=accept+1", acc[0], fs[0]);
        end
        checks++;
        if (!full_ok) begin
            errors++;
            $display("FAIL stream_full_after_5th count=%0d ready=%b expected count 4 ready 0", count[0], ready[0]);
        end
        // ready reopens from the registered count once the second frame's pop lands.
        checks++;
        if (acc[5] != fs[1] + 1) begin
            errors++;
            $display("FAIL stream_sixth_accept accept=%0d frame2_start=%0d expected frame2_start+1", acc[5], fs[1]);
        end
        for (int f = 0; f < 6; f++) begin
            checks++;
            if (got[f] !== {2'b01, seq[f], 1'b0} || gl[f] != 0) begin
                errors++;
                $display("FAIL stream_frame%0d got=%b glitches=%0d expected %b",
                         f, got[f], gl[f], {2'b01, seq[f], 1'b0});
            end
        end
        checks++;
        if (t_end - fs[0] != 240 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL stream_total cycles=%0d busy=%b expected 240 and 0", t_end - fs[0], busy[0]);
        end
    endtask

    task automatic test_push_on_stop();
        logic [7:0]  b [3];
        logic [10:0] got [3];
        int          gl  [3];
        logic [2:0]  pre, post;
        bit          r;
        logic        t0;
        b = '{8'hC3, 8'h9A, 8'h4E};
        @(negedge clk);
        valid[0] = 1'b1;
        data[0]  = b[0];
        @(negedge clk);
        data[0]  = b[1];
        @(negedge clk);
        valid[0] = 1'b0;
        checks++;
        if (count[0] !== 3'd1 || tx[0] !== 1'b0) begin
            errors++;
            $display("FAIL coincide_setup count=%0d tx=%b expected 1 0", count[0], tx[0]);
        end
        fork
            begin
                repeat (39) @(negedge clk);
                pre      = count[0];
                r        = ready[0];
                valid[0] = 1'b1;
                data[0]  = b[2];
                @(negedge clk);
                valid[0] = 1'b0;
                post     = count[0];
                t0       = tx[0];
            end
            begin
                for (int f = 0; f < 3; f++) capture_frame(0, 4, 10, got[f], gl[f]);
            end
        join
        checks++;
        if (pre !== 3'd1 || r !== 1'b1 || post !== 3'd1 || t0 !== 1'b0) begin
            errors++;
            $display("FAIL coincide_count pre=%0d ready=%b post=%0d tx=%b expected 1 1 1 0", pre, r, post, t0);
        end
        for (int f = 0; f < 3; f++) begin
            checks++;
            if (got[f] !== {2'b01, b[f], 1'b0} || gl[f] != 0) begin
                errors++;
                $display("FAIL coincide_frame%0d got=%b glitches=%0d expected %b",
                         f, got[f], gl[f], {2'b01, b[f], 1'b0});
            end
        end
        checks++;
        if (busy[0] !== 1'b0 || tx[0] !== 1'b1) begin
            errors++;
            $display("FAIL coincide_end busy=%b tx=%b expected 0 1", busy[0], tx[0]);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [10:0] got;
        int gl, bad, t;
        bit ok;
        @(negedge clk);
        valid[0] = 1'b1;
        data[0]  = 8'h00;
        @(negedge clk);
        data[0]  = 8'hF0;
        @(negedge clk);
        data[0]  = 8'h0F;
        @(negedge clk);
        valid[0] = 1'b0;
        repeat (16) @(negedge clk);
        checks++;
        if (tx[0] !== 1'b0 || busy[0] !== 1'b1 || count[0] !== 3'd2) begin
            errors++;
            $display("FAIL midframe_pre tx=%b busy=%b count=%0d expected 0 1 2", tx[0], busy[0], count[0]);
        end
        reset[0] = 1'b1;
        #1;
        checks++;
        if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || count[0] !== 3'd0 || ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL async_reset tx=%b busy=%b count=%0d ready=%b expected 1 0 0 0",
                     tx[0], busy[0], count[0], ready[0]);
        end
        @(negedge clk);
        reset[0] = 1'b0;
        bad = 0;
        repeat (60) begin
            @(negedge clk);
            if (tx[0] !== 1'b1 || busy[0] !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL after_reset_quiet bad_samples=%0d expected 0", bad);
        end
        valid[0] = 1'b1;
        data[0]  = 8'h5A;
        @(negedge clk);
        valid[0] = 1'b0;
        wait_start(0, t, ok);
        capture_frame(0, 4, 10, got, gl);
        checks++;
        if (!ok || got !== {2'b01, 8'h5A, 1'b0} || gl != 0 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_frame got=%b glitches=%0d expected %b", got, gl, {2'b01, 8'h5A, 1'b0});
        end
    endtask

    task automatic test_cpb2();
        logic [10:0] got;
        int gl, t, t_end;
        bit ok;
        @(negedge clk);
        valid[3] = 1'b1;
        data[3]  = 8'h80;
        @(negedge clk);
        valid[3] = 1'b0;
        wait_start(3, t, ok);
        capture_frame(3, 2, 10, got, gl);
        t_end = cyc;
        checks++;
        if (!ok || got !== {2'b01, 8'h80, 1'b0} || gl != 0) begin
            errors++;
            $display("FAIL cpb2_frame got=%b glitches=%0d expected %b", got, gl, {2'b01, 8'h80, 1'b0});
        end
        checks++;
        if (t_end - t != 20 || busy[3] !== 1'b0 || tx[3] !== 1'b1) begin
            errors++;
            $display("FAIL cpb2_length cycles=%0d busy=%b tx=%b expected 20 0 1", t_end - t, busy[3], tx[3]);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_parity();
        test_fifo_stream();
        test_push_on_stop();
        test_reset_mid_frame();
        test_cpb2();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
